// File: rtl/encoder_4to2_sync.sv
// Registered 4-to-2 priority encoder with debounce and a valid/ack handshake.
// Ports: clk, rst (sync, high), en, Y[3:0] (active-low requests), ack -> A, B, valid, multi.
module encoder_4to2_sync #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] Y,
   input  logic       ack,
   output logic       A,
   output logic       B,
   output logic       valid,
   output logic       multi
);

   localparam logic [3:0] IDLE_PAT = 4'b1111;
   localparam logic [3:0] LAST     = 4'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD,
      RELEASE
   } state_t;

   state_t     state;
   logic [3:0] s1;
   logic [3:0] ys;
   logic [3:0] pat;
   logic [3:0] cnt;
   logic [1:0] code;
   logic [2:0] ones;
   logic       many;

   // Highest-index low line wins.
   always_comb begin
      code = 2'b00;
      if (!pat[3]) begin
         code = 2'b11;
      end else if (!pat[2]) begin
         code = 2'b10;
      end else if (!pat[1]) begin
         code = 2'b01;
      end
   end

   // More than one low line means at most two lines are high.
   always_comb begin
      ones = 3'(pat[0]) + 3'(pat[1]) + 3'(pat[2]) + 3'(pat[3]);
      many = (ones < 3'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s1    <= IDLE_PAT;
         ys    <= IDLE_PAT;
         pat   <= IDLE_PAT;
         cnt   <= 4'd0;
         A     <= 1'b0;
         B     <= 1'b0;
         valid <= 1'b0;
         multi <= 1'b0;
      end else begin
         s1 <= Y;
         ys <= s1;
         unique case (state)
            IDLE: begin
               if (en && ys != IDLE_PAT) begin
                  pat   <= ys;
                  cnt   <= 4'd0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (!en || ys == IDLE_PAT) begin
                  state <= IDLE;
               end else if (ys != pat) begin
                  // A bounce to another pattern restarts the count.
                  pat <= ys;
                  cnt <= 4'd0;
               end else if (cnt == LAST) begin
                  A     <= code[1];
                  B     <= code[0];
                  multi <= many;
                  valid <= 1'b1;
                  state <= HOLD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            HOLD: begin
               // The code is held until taken; en and Y are ignored here.
               if (ack) begin
                  valid <= 1'b0;
                  cnt   <= 4'd0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (ys != IDLE_PAT) begin
                  cnt <= 4'd0;
               end else if (cnt == LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/encoder_4to2_sync.md
# encoder_4to2_sync

Registered 4-to-2 encoder that sits on the return path of the 2-to-4 active-low decoder. It samples four active-low request lines and debounces them. It then encodes the highest-priority active line into a 2-bit code (A, B) and presents that code with a valid/ack handshake. Each press is reported exactly once: the lines must return to all-high before another capture is allowed.

## Interface
- DEBOUNCE, 4, number of consecutive stable cycles required to accept a press and to accept a release; legal range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- en  in  1  capture enable; 1 allows new captures
- Y  in  4  request lines, active-low; 4'b1111 means idle
- ack  in  1  consumer acknowledge; sampled only while valid=1
- A  out  1  code MSB
- B  out  1  code LSB
- valid  out  1  code available, held until ack
- multi  out  1  more than one line was low in the captured pattern

## Operation
- Synchronizer: Y passes through two flops, s1 then ys. Both reset to 4'b1111. All logic below uses ys only.
- Encoding: the highest-index low bit wins.
  - ys[3]=0 gives AB=11.
  - Otherwise ys[2]=0 gives 10.
  - Otherwise ys[1]=0 gives 01.
  - Otherwise ys[0]=0 gives 00.
  - This is the inverse of the decoder mapping 1110→00, 1101→01, 1011→10, 0111→11.
- multi = 1 when more than one bit of the captured pattern is 0.
- pat: 4-bit latched pattern. cnt: 4-bit counter.
- FSM states and transitions:
  - IDLE:
    - If en=1 and ys≠1111: pat←ys, cnt←0, go to SETTLE.
    - Otherwise stay.
  - SETTLE:
    - If en=0 or ys=1111: go to IDLE.
    - Else if ys≠pat: pat←ys, cnt←0, stay.
    - Else if cnt==DEBOUNCE-1: load A, B and multi from pat, set valid←1, go to HOLD.
    - Else cnt←cnt+1.
  - HOLD:
    - If ack=1: valid←0, cnt←0, go to RELEASE.
    - en and Y are ignored; a pending code is never dropped.
  - RELEASE:
    - If ys≠1111: cnt←0.
    - Else if cnt==DEBOUNCE-1: go to IDLE.
    - Else cnt←cnt+1.
- A, B and multi keep their last captured value until the next capture. They are not cleared on ack.
- cnt saturates by construction and never wraps; the maximum value reached is DEBOUNCE-1.

## Timing
- Reset outputs: A=0, B=0, valid=0, multi=0. Reset internal state: IDLE, s1=ys=pat=4'b1111, cnt=0.
- rst has priority over every other input in any state. Reset during HOLD drops the pending code.
  - If Y is still pressed after reset, the same press is captured again through the normal path.
- Press latency: number clock edges so that edge 1 is the first edge at which s1 samples the new stable Y. With en=1, valid and the new A/B/multi appear after edge DEBOUNCE+3.
  - DEBOUNCE=4 gives edge 7.
  - DEBOUNCE=1 gives edge 4.
- Ack timing:
  - An ack sampled on the same edge at which valid rises has no effect; ack only counts while valid=1 before the edge.
  - With ack held high, valid is high for exactly one cycle.
- Release latency: at least 2+DEBOUNCE edges of Y=1111 after ack, before a new press can start SETTLE.
- Simultaneous events:
  - A pattern change during SETTLE restarts the count; only the final stable pattern is reported.
  - en falling during SETTLE aborts the capture with no output change.

## Test plan
- Reset: Y=1111, drive rst=1 for 2 cycles → A=0, B=0, valid=0, multi=0; all remain 0 for 10 idle cycles.
- Single press: DEBOUNCE=4, en=1, Y=1011 held 20 cycles, ack pulsed 2 cycles after valid rises → valid rises after edge 7 with AB=10 and multi=0, falls on the edge after ack, and no second valid appears while Y stays 1011.
- Bounce: Y alternates 1101/1111 every 2 cycles for 12 cycles, then holds 1101 → exactly one valid, AB=01, rising DEBOUNCE+3 edges after the final transition.
- Priority: Y=0110 → AB=11, multi=1. Release to 1111, then Y=1110 → AB=00, multi=0.
- Enable: en=0 with Y=1110 for 10 cycles → valid stays 0. Raise en with Y still 1110 → valid rises after DEBOUNCE+1 edges with AB=00.
- Reset mid-HOLD: valid=1 with AB=11, then assert rst for 1 cycle with Y held at 0111 → valid=0 and AB=00 after that edge. valid then rises again DEBOUNCE+3 edges after rst is released, with AB=11.
